hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the pipelined ARM core. It generates forwarding selects, load-use and control-hazard stalls and flushes, as the current hazard unit does. It adds a per-register busy scoreboard and a countdown sequencer for one fixed-latency multi-cycle execution unit (multiplier/divider), which writes back through the shared register-file write port. It sits beside the datapath and controller and drives Stall/Flush/Forward for the F/D/E stages.

---
 rtl/hazard_scoreboard_if.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard unit bus: pipeline-stage indices and controls in, forwarding and
// stall/flush controls plus multi-cycle unit status out.
interface hazard_scoreboard_if #(
  parameter int REG_W = 4
);
  // Decode stage
  logic [REG_W-1:0] Ra1D, Ra2D, WA3D;
  logic             Use1D, Use2D, RegWriteD, McStartD;
  // Execute stage
  logic [REG_W-1:0] Ra1E, Ra2E, WA3E;
  logic             RegWriteE, MemtoRegE, McStartE;
  // Memory / writeback stages
  logic [REG_W-1:0] WA3M, WA3W;
  logic             RegWriteM, RegWriteW;
  // PC-write hazard sources
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  // Hazard unit outputs
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE;
  logic             McWriteW;
  logic [REG_W-1:0] McWA3W;
  logic             McBusy;

  // Pipeline side: drives stage information, consumes hazard controls
  modport master (
    output Ra1D, Ra2D, WA3D, Use1D, Use2D, RegWriteD, McStartD,
    output Ra1E, Ra2E, WA3E, RegWriteE, MemtoRegE, McStartE,
    output WA3M, WA3W, RegWriteM, RegWriteW,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  McWriteW, McWA3W, McBusy
  );

  // Hazard unit side
  modport slave (
    input  Ra1D, Ra2D, WA3D, Use1D, Use2D, RegWriteD, McStartD,
    input  Ra1E, Ra2E, WA3E, RegWriteE, MemtoRegE, McStartE,
    input  WA3M, WA3W, RegWriteM, RegWriteW,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output McWriteW, McWA3W, McBusy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the pipelined ARM core: forwarding selects, load-use and
// control-hazard stalls/flushes, plus a per-register busy scoreboard and a
// countdown sequencer for one fixed-latency multi-cycle execution unit that
// writes back through the shared register-file write port.
module hazard_scoreboard #(
  parameter int NREGS  = 16,
  parameter int MC_LAT = 4
) (
  input logic           clk,
  input logic           reset,
  hazard_scoreboard_if.slave hz
);

  localparam int         REG_W  = $clog2(NREGS);
  localparam logic [3:0] LAT_M1 = 4'(MC_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       count, count_nx;
  logic [REG_W-1:0] dest, dest_nx;
  logic [NREGS-1:0] busy, busy_nx;

  logic [1:0] fwd_a, fwd_b;
  logic       ld_stall, mc_stall, pc_wr_pend, stall_d;
  logic       mc_write, accept, mc_busy;

  // RegWriteE carries no hazard information beyond WA3E/McStartE here
  logic unused_inputs;
  assign unused_inputs = hz.RegWriteE;

  // Forwarding selects: memory stage has priority over writeback
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.RegWriteM && (hz.Ra1E == hz.WA3M))      fwd_a = 2'b10;
    else if (hz.RegWriteW && (hz.Ra1E == hz.WA3W)) fwd_a = 2'b01;
    if (hz.RegWriteM && (hz.Ra2E == hz.WA3M))      fwd_b = 2'b10;
    else if (hz.RegWriteW && (hz.Ra2E == hz.WA3W)) fwd_b = 2'b01;
  end

  // Stall sources: load-use, scoreboard RAW/WAW, in-flight issue, PC writes
  always_comb begin
    ld_stall = hz.MemtoRegE &
               ((hz.Use1D & (hz.Ra1D == hz.WA3E)) |
                (hz.Use2D & (hz.Ra2D == hz.WA3E)));
    mc_stall = (hz.Use1D & busy[hz.Ra1D]) |
               (hz.Use2D & busy[hz.Ra2D]) |
               (hz.RegWriteD & busy[hz.WA3D]) |
               (hz.McStartE & ((hz.Use1D & (hz.Ra1D == hz.WA3E)) |
                               (hz.Use2D & (hz.Ra2D == hz.WA3E)) |
                               (hz.RegWriteD & (hz.WA3D == hz.WA3E)))) |
               (hz.McStartD & (mc_busy | hz.McStartE));
    pc_wr_pend = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
    stall_d    = ld_stall | mc_stall;
  end

  assign mc_busy  = (state != S_IDLE);
  // The pipeline writer always owns the write port; the unit waits for a gap
  assign mc_write = (state == S_DONE) & ~hz.RegWriteW;
  // A new op is taken when idle, or on the edge that retires the current one
  assign accept   = hz.McStartE & ((state == S_IDLE) | mc_write);

  // Sequencer and scoreboard next-state
  always_comb begin
    state_nx = state;
    count_nx = count;
    dest_nx  = dest;
    busy_nx  = busy;
    case (state)
      S_RUN: begin
        count_nx = count - 4'd1;
        if (count == 4'd1) state_nx = S_DONE;
      end
      S_DONE: begin
        if (mc_write) begin
          busy_nx[dest] = 1'b0;
          state_nx      = S_IDLE;
          count_nx      = '0;
          dest_nx       = '0;
        end
      end
      default: ;
    endcase
    // Retire-then-issue on the same edge: the new destination's set wins
    if (accept) begin
      busy_nx[hz.WA3E] = 1'b1;
      dest_nx          = hz.WA3E;
      count_nx         = LAT_M1;
      state_nx         = (MC_LAT == 1) ? S_DONE : S_RUN;
    end
  end

  // State register; reset abandons any pending op without writing back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
      dest  <= '0;
      busy  <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      dest  <= dest_nx;
      busy  <= busy_nx;
    end
  end

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallD    = stall_d;
  assign hz.StallF    = stall_d | pc_wr_pend;
  assign hz.FlushE    = stall_d | hz.BranchTakenE;
  assign hz.FlushD    = pc_wr_pend | hz.PCSrcW | hz.BranchTakenE;
  assign hz.McWriteW  = mc_write;
  assign hz.McWA3W    = dest;
  assign hz.McBusy    = mc_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NREGS=16, MC_LAT=4). Each step drives
// the stage inputs, queues the expected output snapshot, and compares it with
// the DUT outputs sampled on the falling edge.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(4)) bus ();

  hazard_scoreboard #(.NREGS(16), .MC_LAT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bus)
  );

  typedef struct {
    string      tag;
    logic [13:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [13:0] observed();
    return {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.FlushD,
            bus.FlushE, bus.McWriteW, bus.McWA3W, bus.McBusy};
  endfunction

  task automatic clr();
    bus.Ra1D = '0; bus.Ra2D = '0; bus.WA3D = '0;
    bus.Use1D = 1'b0; bus.Use2D = 1'b0; bus.RegWriteD = 1'b0; bus.McStartD = 1'b0;
    bus.Ra1E = '0; bus.Ra2E = '0; bus.WA3E = '0;
    bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0; bus.McStartE = 1'b0;
    bus.WA3M = '0; bus.WA3W = '0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    bus.PCSrcD = 1'b0; bus.PCSrcE = 1'b0; bus.PCSrcM = 1'b0; bus.PCSrcW = 1'b0;
    bus.BranchTakenE = 1'b0;
  endtask

  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic sf, input logic sd, input logic fd, input logic fe,
                      input logic mw, input logic [3:0] wa, input logic mb);
    exp_t e;
    logic [13:0] obs;
    e.tag = tag;
    e.val = {fa, fb, sf, sd, fd, fe, mw, wa, mb};
    q.push_back(e);
    @(negedge clk);
    e   = q.pop_front();
    obs = observed();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
    end
    @(posedge clk);
    #1;
  endtask

  // No forwarding, no PC hazard: StallF/StallD/FlushE all follow the decode stall
  task automatic chk(input string tag, input logic sd, input logic mw,
                     input logic [3:0] wa, input logic mb);
    step(tag, 2'b00, 2'b00, sd, sd, 1'b0, sd, mw, wa, mb);
  endtask

  initial begin
    reset = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // Reset state and combinational paths during reset
    chk("rst_idle", 1'b0, 1'b0, 4'd0, 1'b0);
    bus.BranchTakenE = 1'b1;
    step("rst_comb", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    clr();
    reset = 1'b1;
    chk("post_rst", 1'b0, 1'b0, 4'd0, 1'b0);

    // Forwarding
    bus.RegWriteM = 1'b1; bus.RegWriteW = 1'b1;
    bus.WA3M = 4'd3; bus.WA3W = 4'd3; bus.Ra1E = 4'd3; bus.Ra2E = 4'd5;
    step("fwd_m_prio", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    bus.RegWriteM = 1'b0;
    step("fwd_w", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd5;
    step("fwd_mix", 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    step("fwd_none", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    clr();

    // Load-use
    bus.MemtoRegE = 1'b1; bus.WA3E = 4'd2; bus.Use1D = 1'b1; bus.Ra1D = 4'd2;
    chk("ldr_a", 1'b1, 1'b0, 4'd0, 1'b0);
    bus.MemtoRegE = 1'b0; bus.WA3E = 4'd0;
    chk("ldr_release", 1'b0, 1'b0, 4'd0, 1'b0);
    bus.MemtoRegE = 1'b1; bus.WA3E = 4'd2; bus.Use1D = 1'b0; bus.Use2D = 1'b1; bus.Ra2D = 4'd2;
    chk("ldr_b", 1'b1, 1'b0, 4'd0, 1'b0);
    bus.Use2D = 1'b0;
    chk("ldr_nouse", 1'b0, 1'b0, 4'd0, 1'b0);
    clr();

    // Control hazards
    bus.BranchTakenE = 1'b1;
    step("br_taken", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    clr(); bus.PCSrcD = 1'b1;
    step("pcsrc_d", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    clr(); bus.PCSrcW = 1'b1;
    step("pcsrc_w", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    clr();

    // Multi-cycle dependency on R7
    bus.McStartE = 1'b1; bus.RegWriteE = 1'b1; bus.WA3E = 4'd7;
    bus.Use1D = 1'b1; bus.Ra1D = 4'd7;
    chk("mc_t0", 1'b1, 1'b0, 4'd0, 1'b0);
    bus.McStartE = 1'b0; bus.RegWriteE = 1'b0; bus.WA3E = 4'd0;
    chk("mc_t1", 1'b1, 1'b0, 4'd7, 1'b1);
    bus.Use1D = 1'b0; bus.RegWriteD = 1'b1; bus.WA3D = 4'd7;
    chk("mc_t2_waw", 1'b1, 1'b0, 4'd7, 1'b1);
    bus.RegWriteD = 1'b0; bus.WA3D = 4'd0; bus.McStartD = 1'b1;
    chk("mc_t3_busy", 1'b1, 1'b0, 4'd7, 1'b1);
    bus.McStartD = 1'b0; bus.Use1D = 1'b1;
    chk("mc_t4_write", 1'b1, 1'b1, 4'd7, 1'b1);
    chk("mc_t5_release", 1'b0, 1'b0, 4'd0, 1'b0);
    clr();

    // Write-port contention in DONE
    bus.McStartE = 1'b1; bus.WA3E = 4'd7;
    chk("ct_issue", 1'b0, 1'b0, 4'd0, 1'b0);
    bus.McStartE = 1'b0; bus.WA3E = 4'd0; bus.Use1D = 1'b1; bus.Ra1D = 4'd7;
    for (int i = 0; i < 3; i++) chk("ct_run", 1'b1, 1'b0, 4'd7, 1'b1);
    bus.RegWriteW = 1'b1; bus.WA3W = 4'd9;
    chk("ct_defer1", 1'b1, 1'b0, 4'd7, 1'b1);
    chk("ct_defer2", 1'b1, 1'b0, 4'd7, 1'b1);
    bus.RegWriteW = 1'b0;
    chk("ct_write", 1'b1, 1'b1, 4'd7, 1'b1);
    chk("ct_release", 1'b0, 1'b0, 4'd0, 1'b0);
    clr();

    // Back-to-back issue and ignored McStartE while busy
    bus.McStartE = 1'b1; bus.WA3E = 4'd4;
    chk("bb_issue1", 1'b0, 1'b0, 4'd0, 1'b0);
    bus.McStartE = 1'b0; bus.WA3E = 4'd0;
    for (int i = 0; i < 3; i++) chk("bb_run1", 1'b0, 1'b0, 4'd4, 1'b1);
    bus.McStartE = 1'b1; bus.WA3E = 4'd6;
    chk("bb_write1", 1'b0, 1'b1, 4'd4, 1'b1);
    bus.McStartE = 1'b0; bus.WA3E = 4'd0; bus.Use1D = 1'b1; bus.Ra1D = 4'd4;
    chk("bb_freed", 1'b0, 1'b0, 4'd6, 1'b1);
    bus.Use1D = 1'b0; bus.Use2D = 1'b1; bus.Ra2D = 4'd6;
    chk("bb_busy2", 1'b1, 1'b0, 4'd6, 1'b1);
    bus.Use2D = 1'b0; bus.McStartE = 1'b1; bus.WA3E = 4'd8;
    chk("bb_ignore_in", 1'b0, 1'b0, 4'd6, 1'b1);
    bus.McStartE = 1'b0; bus.WA3E = 4'd0; bus.Use1D = 1'b1; bus.Ra1D = 4'd8;
    chk("bb_write2", 1'b0, 1'b1, 4'd6, 1'b1);
    clr();
    chk("bb_idle", 1'b0, 1'b0, 4'd0, 1'b0);

    // Reset in the middle of an op
    bus.McStartE = 1'b1; bus.WA3E = 4'd7;
    chk("rm_issue", 1'b0, 1'b0, 4'd0, 1'b0);
    bus.McStartE = 1'b0; bus.WA3E = 4'd0; bus.Use1D = 1'b1; bus.Ra1D = 4'd7;
    chk("rm_t1", 1'b1, 1'b0, 4'd7, 1'b1);
    reset = 1'b0;
    chk("rm_reset", 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) chk("rm_nowrite", 1'b0, 1'b0, 4'd0, 1'b0);
    clr();
    bus.McStartE = 1'b1; bus.WA3E = 4'd2;
    chk("rm_reissue", 1'b0, 1'b0, 4'd0, 1'b0);
    bus.McStartE = 1'b0; bus.WA3E = 4'd0;
    for (int i = 0; i < 3; i++) chk("rm_run", 1'b0, 1'b0, 4'd2, 1'b1);
    chk("rm_write", 1'b0, 1'b1, 4'd2, 1'b1);
    chk("rm_idle", 1'b0, 1'b0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
